// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states,
// default latencies and small op-class helpers.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_t;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_t;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;
  // Countdown width; latencies must stay below 2**MDU_CNT_W.
  localparam int MDU_CNT_W       = 8;

  function automatic logic is_div(input logic [3:0] o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

  function automatic logic is_muldiv(input logic [3:0] o);
    return (o == MDU_MULT) || (o == MDU_MULTU) || is_div(o);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing {hi, lo}.
// Division results are {remainder, quotient}; a zero divisor raises div_zero
// and the datapath divides by one instead so no X escapes.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] s_prod;
  logic        [63:0] u_prod;
  logic signed [31:0] s_quo;
  logic signed [31:0] s_rem;
  logic        [31:0] u_quo;
  logic        [31:0] u_rem;
  logic        [31:0] b_safe;
  logic               s_ovf;

  assign div_zero = (b == 32'd0);
  assign b_safe   = div_zero ? 32'd1 : b;
  // Most-negative / -1 overflows a 32-bit quotient; pin it to the wrapped value.
  assign s_ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  assign s_prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign u_prod = {32'd0, a} * {32'd0, b};
  assign s_quo  = s_ovf ? $signed(a) : ($signed(a) / $signed(b_safe));
  assign s_rem  = s_ovf ? 32'sd0     : ($signed(a) % $signed(b_safe));
  assign u_quo  = a / b_safe;
  assign u_rem  = a % b_safe;

  // Select the result matching the requested operation.
  always_comb begin
    result = 64'd0;
    case (op)
      MDU_MULT:  result = s_prod;
      MDU_MULTU: result = u_prod;
      MDU_DIV:   result = {s_rem, s_quo};
      MDU_DIVU:  result = {u_rem, u_quo};
      default:   result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// HI/LO register file with multi-cycle multiply/divide latency model.
// Handshake: an op is accepted when start=1, req=0 and the unit is IDLE; a
// mult/div result is held in a pending register and committed to HI/LO on the
// edge ending the last busy cycle. MTHI/MTLO write in the accepting edge.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic        req,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data,
  output mdu_state_t  state
);

  mdu_state_t           state_next;
  logic [MDU_CNT_W-1:0] count;
  logic [63:0]          pend;
  logic                 pend_wr;
  logic [63:0]          arith_result;
  logic                 div_zero;
  logic                 accept;
  logic                 acc_muldiv;
  logic                 commit;

  mdu_arith u_arith (
    .op       (op),
    .a        (rs_data),
    .b        (rt_data),
    .result   (arith_result),
    .div_zero (div_zero)
  );

  assign accept     = start && !req && (state == MDU_IDLE);
  assign acc_muldiv = accept && is_muldiv(op);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= MDU_IDLE;
    else          state <= state_next;
  end

  // Next state: start a countdown on an accepted mult/div, leave on commit.
  always_comb begin
    state_next = state;
    case (state)
      MDU_IDLE: if (acc_muldiv) state_next = MDU_RUN;
      MDU_RUN:  if (count == MDU_CNT_W'(1)) state_next = MDU_IDLE;
      default:  state_next = MDU_IDLE;
    endcase
  end

  // FSM outputs: busy while counting, commit on the last busy cycle.
  always_comb begin
    busy   = (state == MDU_RUN);
    commit = (state == MDU_RUN) && (count == MDU_CNT_W'(1));
  end

  // Latency countdown.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (acc_muldiv) begin
      count <= is_div(op) ? MDU_CNT_W'(DIV_CYCLES) : MDU_CNT_W'(MULT_CYCLES);
    end else if ((state == MDU_RUN) && (count != '0)) begin
      count <= count - MDU_CNT_W'(1);
    end
  end

  // Capture the result at acceptance; a zero divisor marks it as no-write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend    <= '0;
      pend_wr <= 1'b0;
    end else if (acc_muldiv) begin
      pend    <= arith_result;
      pend_wr <= !(is_div(op) && div_zero);
    end
  end

  // Architectural HI/LO: pending commit or direct move-to writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      if (pend_wr) begin
        hi <= pend[63:32];
        lo <= pend[31:0];
      end
    end else if (accept && (op == MDU_MTHI)) begin
      hi <= rs_data;
    end else if (accept && (op == MDU_MTLO)) begin
      lo <= rs_data;
    end
  end

  // Read port into the EX result mux.
  always_comb begin
    rd_data = 32'd0;
    case (op)
      MDU_MFHI: rd_data = hi;
      MDU_MFLO: rd_data = lo;
      default:  rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: vector table of mult/div ops scored
// through an expected queue, plus directed reset/squash/busy sequences.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  op = MDU_NONE;
  logic        start = 1'b0;
  logic        req = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;
  mdu_state_t  state;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  mdu_hilo dut (
    .clk     (clk),
    .reset_n (reset_n),
    .op      (op),
    .start   (start),
    .req     (req),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data),
    .state   (state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one op for one cycle; returns at the negedge of cycle 1.
  task automatic issue(input logic [3:0] op_i, input logic [31:0] rs_i,
                       input logic [31:0] rt_i, input logic req_i);
    @(negedge clk);
    op = op_i; start = 1'b1; rs_data = rs_i; rt_data = rt_i; req = req_i;
    @(negedge clk);
    op = MDU_NONE; start = 1'b0; req = 1'b0;
  endtask

  task automatic write_hilo(input logic to_hi, input logic [31:0] v);
    issue(to_hi ? 4'(MDU_MTHI) : 4'(MDU_MTLO), v, 32'd0, 1'b0);
    if (to_hi) m_hi = v;
    else       m_lo = v;
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
  endtask

  // Issue a mult/div, check busy for n cycles, then score the commit.
  task automatic run_muldiv(input string name, input logic [3:0] op_i,
                            input logic [31:0] rs_i, input logic [31:0] rt_i,
                            input int n, input logic [31:0] eh, input logic [31:0] el);
    logic [63:0] e;
    exp_q.push_back({eh, el});
    issue(op_i, rs_i, rt_i, 1'b0);
    for (int k = 1; k <= n; k++) begin
      check({name, "_busy"}, {31'd0, busy}, 32'd1);
      check({name, "_hold_hi"}, hi, m_hi);
      @(negedge clk);
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_hi"}, hi, e[63:32]);
      check({name, "_lo"}, lo, e[31:0]);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
  endtask

  initial begin
    vecs[0] = '{MDU_MULT,  32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{MDU_DIVU,  32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC};
    vecs[4] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[5] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[6] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{MDU_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
    vecs[8] = '{MDU_MULT,  32'd3,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[9] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd7,         32'h0000_0000, 32'hFFFF_FFFF};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_rd", rd_data, 32'd0);
    check("rst_state", {31'd0, state}, {31'd0, MDU_IDLE});
    reset_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      run_muldiv($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                 is_div(vecs[i].op) ? MDU_DIV_CYCLES : MDU_MULT_CYCLES,
                 vecs[i].hi, vecs[i].lo);
    end

    // Random move-to values read back through MFHI/MFLO.
    for (int i = 0; i < 4; i++) begin
      write_hilo(i[0] == 1'b0, $urandom_range(32'hFFFF_FFFF, 0));
      @(negedge clk);
      op = MDU_MFHI; #1 check("rand_mfhi", rd_data, m_hi);
      op = MDU_MFLO; #1 check("rand_mflo", rd_data, m_lo);
      op = MDU_NONE;
    end

    // Divide by zero keeps HI/LO and still runs the full latency.
    write_hilo(1'b1, 32'h1234_5678);
    write_hilo(1'b0, 32'h9ABC_DEF0);
    run_muldiv("div0", MDU_DIV, 32'd55, 32'd0, MDU_DIV_CYCLES, 32'h1234_5678, 32'h9ABC_DEF0);
    op = MDU_MFHI; #1 check("div0_mfhi", rd_data, 32'h1234_5678);
    op = MDU_MFLO; #1 check("div0_mflo", rd_data, 32'h9ABC_DEF0);
    op = MDU_NONE; #1 check("none_rd", rd_data, 32'd0);

    // Squashed MTLO and MULT, illegal op.
    issue(MDU_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b1);
    check("sq_mtlo_lo", lo, m_lo);
    issue(MDU_MULT, 32'd3, 32'd4, 1'b1);
    check("sq_mult_busy", {31'd0, busy}, 32'd0);
    issue(4'hF, 32'hCAFE_F00D, 32'd1, 1'b0);
    check("ill_busy", {31'd0, busy}, 32'd0);
    check("ill_hi", hi, m_hi);
    check("ill_lo", lo, m_lo);

    // Start during busy is ignored; original MULT commits on schedule.
    exp_q.push_back({32'd0, 32'd12});
    issue(MDU_MULT, 32'd3, 32'd4, 1'b0);
    for (int k = 1; k <= MDU_MULT_CYCLES; k++) begin
      check("ign_busy", {31'd0, busy}, 32'd1);
      check("ign_lo_hold", lo, m_lo);
      check("ign_hi_hold", hi, m_hi);
      start   = (k < MDU_MULT_CYCLES);
      op      = k[0] ? 4'(MDU_MTLO) : 4'(MDU_DIV);
      rs_data = 32'hDEAD_BEEF;
      rt_data = 32'd7;
      @(negedge clk);
    end
    start = 1'b0; op = MDU_NONE;
    begin
      logic [63:0] e;
      e = exp_q.pop_front();
      check("ign_idle", {31'd0, busy}, 32'd0);
      check("ign_hi", hi, e[63:32]);
      check("ign_lo", lo, e[31:0]);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
    @(negedge clk);
    check("ign_no_requeue", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-operation discards the pending result.
    write_hilo(1'b1, 32'hA5A5_A5A5);
    write_hilo(1'b0, 32'h5A5A_5A5A);
    issue(MDU_MULT, 32'd7, 32'd6, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (MDU_MULT_CYCLES + 2) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
